// File: rtl/decode_stage_if.sv
// Fetch/writeback-to-execute bundle for the RV32I decode stage.
// The master side drives instruction/writeback inputs; the slave (decode_stage) drives *_exec.
interface decode_stage_if;
   logic [31:0] instr_decode;
   logic [31:0] pc_decode;
   logic [31:0] next_pc_decode;
   logic        stall_decode;
   logic        flush_decode;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic [31:0] pc_exec;
   logic [31:0] next_pc_exec;
   logic [31:0] imm_exec;
   logic [31:0] rd1_exec;
   logic [31:0] rd2_exec;
   logic [4:0]  rs1_exec;
   logic [4:0]  rs2_exec;
   logic [4:0]  rd_exec;
   logic [3:0]  alu_ctrl_exec;
   logic [2:0]  funct3_exec;
   logic [1:0]  result_src_exec;
   logic        alu_src_exec;
   logic        alu_a_pc_exec;
   logic        reg_write_exec;
   logic        mem_write_exec;
   logic        branch_exec;
   logic        jump_exec;
   logic        illegal_exec;

   modport master (
      output instr_decode, pc_decode, next_pc_decode, stall_decode, flush_decode,
             wb_en, wb_rd, wb_data,
      input  pc_exec, next_pc_exec, imm_exec, rd1_exec, rd2_exec, rs1_exec, rs2_exec,
             rd_exec, alu_ctrl_exec, funct3_exec, result_src_exec, alu_src_exec,
             alu_a_pc_exec, reg_write_exec, mem_write_exec, branch_exec, jump_exec,
             illegal_exec
   );

   modport slave (
      input  instr_decode, pc_decode, next_pc_decode, stall_decode, flush_decode,
             wb_en, wb_rd, wb_data,
      output pc_exec, next_pc_exec, imm_exec, rd1_exec, rd2_exec, rs1_exec, rs2_exec,
             rd_exec, alu_ctrl_exec, funct3_exec, result_src_exec, alu_src_exec,
             alu_a_pc_exec, reg_write_exec, mem_write_exec, branch_exec, jump_exec,
             illegal_exec
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode + 32x32 register file feeding one execute register.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data onto the read ports.
module decode_stage (
   input  logic          clk,
   input  logic          rst_n,
   decode_stage_if.slave dif
);

   localparam int DATA_W = 32;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] next_pc;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic [3:0]        alu_ctrl;
      logic [2:0]        funct3;
      logic [1:0]        result_src;
      logic              alu_src;
      logic              alu_a_pc;
      logic              reg_write;
      logic              mem_write;
      logic              branch;
      logic              jump;
      logic              illegal;
   } exec_t;

   function automatic logic signed [DATA_W-1:0] imm_i(input logic [31:0] ins);
      return {{20{ins[31]}}, ins[31:20]};
   endfunction

   function automatic logic signed [DATA_W-1:0] imm_s(input logic [31:0] ins);
      return {{20{ins[31]}}, ins[31:25], ins[11:7]};
   endfunction

   function automatic logic signed [DATA_W-1:0] imm_b(input logic [31:0] ins);
      return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   endfunction

   function automatic logic signed [DATA_W-1:0] imm_u(input logic [31:0] ins);
      return {ins[31:12], 12'b0};
   endfunction

   function automatic logic signed [DATA_W-1:0] imm_j(input logic [31:0] ins);
      return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

   // funct7[5] selects SUB only for register-register ops; SRA for both R and I forms.
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                              input logic is_r);
      case (f3)
         3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   logic [31:0] instr_p0;
   logic [6:0]  opcode_p0;
   logic [4:0]  rs1_p0;
   logic [4:0]  rs2_p0;
   logic [DATA_W-1:0] rd1_p0;
   logic [DATA_W-1:0] rd2_p0;
   logic        byp1_p0;
   logic        byp2_p0;
   logic [DATA_W-1:0] regs [32];
   exec_t       dec_p0;
   exec_t       exec_p1;

   assign instr_p0  = dif.instr_decode;
   assign opcode_p0 = instr_p0[6:0];
   assign rs1_p0    = instr_p0[19:15];
   assign rs2_p0    = instr_p0[24:20];

   // Register file; entry 0 is never written and reads are forced to zero anyway.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (dif.wb_en && (dif.wb_rd != 5'd0)) begin
         regs[dif.wb_rd] <= dif.wb_data;
      end
   end

`ifdef DECODE_WB_BYPASS_EN
   assign byp1_p0 = dif.wb_en && (dif.wb_rd == rs1_p0);
   assign byp2_p0 = dif.wb_en && (dif.wb_rd == rs2_p0);
`else
   assign byp1_p0 = 1'b0;
   assign byp2_p0 = 1'b0;
`endif

   assign rd1_p0 = (rs1_p0 == 5'd0) ? '0 : (byp1_p0 ? dif.wb_data : regs[rs1_p0]);
   assign rd2_p0 = (rs2_p0 == 5'd0) ? '0 : (byp2_p0 ? dif.wb_data : regs[rs2_p0]);

   always_comb begin
      dec_p0          = '0;
      dec_p0.pc       = dif.pc_decode;
      dec_p0.next_pc  = dif.next_pc_decode;
      dec_p0.rd1      = rd1_p0;
      dec_p0.rd2      = rd2_p0;
      dec_p0.rs1      = rs1_p0;
      dec_p0.rs2      = rs2_p0;
      dec_p0.rd       = instr_p0[11:7];
      dec_p0.funct3   = instr_p0[14:12];
      case (opcode_p0)
         OP_R: begin
            dec_p0.reg_write = 1'b1;
            dec_p0.alu_ctrl  = alu_from_f3(instr_p0[14:12], instr_p0[30], 1'b1);
         end
         OP_IALU: begin
            dec_p0.reg_write = 1'b1;
            dec_p0.alu_src   = 1'b1;
            dec_p0.imm       = imm_i(instr_p0);
            dec_p0.alu_ctrl  = alu_from_f3(instr_p0[14:12], instr_p0[30], 1'b0);
         end
         OP_LOAD: begin
            dec_p0.reg_write  = 1'b1;
            dec_p0.alu_src    = 1'b1;
            dec_p0.result_src = 2'b01;
            dec_p0.imm        = imm_i(instr_p0);
         end
         OP_STORE: begin
            dec_p0.mem_write = 1'b1;
            dec_p0.alu_src   = 1'b1;
            dec_p0.imm       = imm_s(instr_p0);
         end
         OP_BR: begin
            dec_p0.branch   = 1'b1;
            dec_p0.alu_ctrl = ALU_SUB;
            dec_p0.imm      = imm_b(instr_p0);
         end
         // JAL computes its target as PC + imm; JALR as rs1 + imm.
         OP_JAL: begin
            dec_p0.reg_write  = 1'b1;
            dec_p0.jump       = 1'b1;
            dec_p0.result_src = 2'b10;
            dec_p0.alu_src    = 1'b1;
            dec_p0.alu_a_pc   = 1'b1;
            dec_p0.imm        = imm_j(instr_p0);
         end
         OP_JALR: begin
            dec_p0.reg_write  = 1'b1;
            dec_p0.jump       = 1'b1;
            dec_p0.result_src = 2'b10;
            dec_p0.alu_src    = 1'b1;
            dec_p0.imm        = imm_i(instr_p0);
         end
         OP_LUI: begin
            dec_p0.reg_write = 1'b1;
            dec_p0.alu_src   = 1'b1;
            dec_p0.alu_ctrl  = ALU_PASS;
            dec_p0.imm       = imm_u(instr_p0);
         end
         OP_AUIPC: begin
            dec_p0.reg_write = 1'b1;
            dec_p0.alu_src   = 1'b1;
            dec_p0.alu_a_pc  = 1'b1;
            dec_p0.imm       = imm_u(instr_p0);
         end
         default: begin
            dec_p0.imm     = '0;
            dec_p0.illegal = 1'b1;
         end
      endcase
   end

   // ---- p0 -> p1: execute-side register (flush beats stall beats capture) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_p1 <= '0;
      end else if (dif.flush_decode) begin
         exec_p1 <= '0;
      end else if (!dif.stall_decode) begin
         exec_p1 <= dec_p0;
      end
   end

   assign dif.pc_exec         = exec_p1.pc;
   assign dif.next_pc_exec    = exec_p1.next_pc;
   assign dif.imm_exec        = exec_p1.imm;
   assign dif.rd1_exec        = exec_p1.rd1;
   assign dif.rd2_exec        = exec_p1.rd2;
   assign dif.rs1_exec        = exec_p1.rs1;
   assign dif.rs2_exec        = exec_p1.rs2;
   assign dif.rd_exec         = exec_p1.rd;
   assign dif.alu_ctrl_exec   = exec_p1.alu_ctrl;
   assign dif.funct3_exec     = exec_p1.funct3;
   assign dif.result_src_exec = exec_p1.result_src;
   assign dif.alu_src_exec    = exec_p1.alu_src;
   assign dif.alu_a_pc_exec   = exec_p1.alu_a_pc;
   assign dif.reg_write_exec  = exec_p1.reg_write;
   assign dif.mem_write_exec  = exec_p1.mem_write;
   assign dif.branch_exec     = exec_p1.branch;
   assign dif.jump_exec       = exec_p1.jump;
   assign dif.illegal_exec    = exec_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed + randomized bench for decode_stage against a mnemonic-level reference model.
// Honours DECODE_WB_BYPASS_EN in the model when the macro is defined.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] pc, npc, imm, rd1, rd2;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  alu;
      logic [2:0]  f3;
      logic [1:0]  res;
      logic        asrc, apc, rw, mw, br, jmp, ill;
   } exp_t;

`ifdef DECODE_WB_BYPASS_EN
   localparam logic [31:0] BYP_EXP = 32'h1234;
`else
   localparam logic [31:0] BYP_EXP = 32'h0;
`endif

   logic        clk;
   logic        rst_n;
   int          total = 0;
   int          bad   = 0;
   logic [31:0] mregs [32];
   exp_t        exp_q;

   decode_stage_if dif ();

   decode_stage u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dif   (dif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Two's-complement sign extension of a 'bits'-wide field, done arithmetically.
   function automatic logic [31:0] sext(input int v, input int bits);
      int half;
      half = 1 << (bits - 1);
      return 32'((v ^ half) - half);
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] ins, pc, npc, v1, v2);
      exp_t e;
      int   alu_tab [8];
      int   f3;
      alu_tab = '{0, 7, 5, 6, 4, 8, 3, 2};
      f3 = int'(ins[14:12]);
      e = '0;
      e.pc = pc; e.npc = npc; e.rd1 = v1; e.rd2 = v2;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = ins[14:12];
      case (ins[6:0])
         7'h33: begin
            e.rw = 1; e.alu = 4'(alu_tab[f3]);
            if (ins[30] && f3 == 0) e.alu = 4'd1;
            if (ins[30] && f3 == 5) e.alu = 4'd9;
         end
         7'h13: begin
            e.rw = 1; e.asrc = 1; e.imm = sext(int'(ins[31:20]), 12); e.alu = 4'(alu_tab[f3]);
            if (ins[30] && f3 == 5) e.alu = 4'd9;
         end
         7'h03: begin e.rw = 1; e.asrc = 1; e.res = 2'd1; e.imm = sext(int'(ins[31:20]), 12); end
         7'h23: begin e.mw = 1; e.asrc = 1; e.imm = sext(int'({ins[31:25], ins[11:7]}), 12); end
         7'h63: begin
            e.br = 1; e.alu = 4'd1;
            e.imm = sext(int'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12) * 2;
         end
         7'h6F: begin
            e.rw = 1; e.jmp = 1; e.res = 2'd2; e.asrc = 1; e.apc = 1;
            e.imm = sext(int'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20) * 2;
         end
         7'h67: begin
            e.rw = 1; e.jmp = 1; e.res = 2'd2; e.asrc = 1; e.imm = sext(int'(ins[31:20]), 12);
         end
         7'h37: begin e.rw = 1; e.asrc = 1; e.alu = 4'd10; e.imm = ins[31:12] * 4096; end
         7'h17: begin e.rw = 1; e.asrc = 1; e.apc = 1; e.imm = ins[31:12] * 4096; end
         default: e.ill = 1;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] rf_ref(input logic [4:0] idx, input logic wen,
                                          input logic [4:0] wrd, input logic [31:0] wdat);
      if (idx == 5'd0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
      if (wen && wrd == idx) return wdat;
`endif
      return mregs[idx];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string t);
      chk({t, ".pc"},      dif.pc_exec,         exp_q.pc);
      chk({t, ".npc"},     dif.next_pc_exec,    exp_q.npc);
      chk({t, ".imm"},     dif.imm_exec,        exp_q.imm);
      chk({t, ".rd1"},     dif.rd1_exec,        exp_q.rd1);
      chk({t, ".rd2"},     dif.rd2_exec,        exp_q.rd2);
      chk({t, ".rs1"},     32'(dif.rs1_exec),   32'(exp_q.rs1));
      chk({t, ".rs2"},     32'(dif.rs2_exec),   32'(exp_q.rs2));
      chk({t, ".rd"},      32'(dif.rd_exec),    32'(exp_q.rd));
      chk({t, ".alu"},     32'(dif.alu_ctrl_exec), 32'(exp_q.alu));
      chk({t, ".f3"},      32'(dif.funct3_exec),   32'(exp_q.f3));
      chk({t, ".res"},     32'(dif.result_src_exec), 32'(exp_q.res));
      chk({t, ".flags"},
          32'({dif.alu_src_exec, dif.alu_a_pc_exec, dif.reg_write_exec, dif.mem_write_exec,
               dif.branch_exec, dif.jump_exec, dif.illegal_exec}),
          32'({exp_q.asrc, exp_q.apc, exp_q.rw, exp_q.mw, exp_q.br, exp_q.jmp, exp_q.ill}));
   endtask

   // Drive one cycle's inputs, advance the model, clock, then compare after the edge.
   task automatic cycle(input string t, input logic [31:0] ins, input logic [31:0] pc,
                        input logic stall, input logic flush, input logic wen,
                        input logic [4:0] wrd, input logic [31:0] wdat);
      logic [31:0] v1, v2;
      dif.instr_decode   = ins;
      dif.pc_decode      = pc;
      dif.next_pc_decode = pc + 32'd4;
      dif.stall_decode   = stall;
      dif.flush_decode   = flush;
      dif.wb_en          = wen;
      dif.wb_rd          = wrd;
      dif.wb_data        = wdat;
      v1 = rf_ref(ins[19:15], wen, wrd, wdat);
      v2 = rf_ref(ins[24:20], wen, wrd, wdat);
      if (flush)       exp_q = '0;
      else if (!stall) exp_q = ref_decode(ins, pc, pc + 32'd4, v1, v2);
      if (wen && wrd != 5'd0) mregs[wrd] = wdat;
      @(posedge clk);
      #1;
      check_all(t);
   endtask

   task automatic reset_pulse(input string t);
      rst_n = 1'b0;
      #2;
      exp_q = '0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      check_all(t);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      logic [6:0]  ops [10];
      logic [31:0] r;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
      rst_n = 1'b0;
      dif.instr_decode = '0; dif.pc_decode = '0; dif.next_pc_decode = '0;
      dif.stall_decode = 1'b0; dif.flush_decode = 1'b0;
      dif.wb_en = 1'b0; dif.wb_rd = '0; dif.wb_data = '0;
      exp_q = '0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      #12;
      check_all("reset");
      rst_n = 1'b1;

      // Same-cycle writeback of x1 against a read of x1.
      cycle("byp", 32'h000081B3, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1234);
      chk("byp.rd1_const", dif.rd1_exec, BYP_EXP);

      cycle("addi", 32'h00500093, 32'h10, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("addi.rd_c", 32'(dif.rd_exec), 32'd1);
      chk("addi.imm_c", dif.imm_exec, 32'd5);
      chk("addi.ctl_c", 32'({dif.alu_src_exec, dif.reg_write_exec, dif.alu_ctrl_exec}), 32'h30);
      chk("addi.pc_c", dif.pc_exec, 32'h10);

      cycle("beq", 32'h00208463, 32'h14, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("beq.imm_c", dif.imm_exec, 32'd8);
      chk("beq.ctl_c", 32'({dif.branch_exec, dif.reg_write_exec, dif.alu_ctrl_exec}), 32'h21);
      chk("beq.rs_c", 32'({dif.rs1_exec, dif.rs2_exec}), 32'h22);

      // Capture, then stall with new instructions, then stall+flush.
      cycle("cap", 32'h00500093, 32'h20, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      cycle("stl0", 32'h00208463, 32'h24, 1'b1, 1'b0, 1'b1, 5'd2, 32'hCAFE);
      cycle("stl1", 32'hFFFFFFFF, 32'h28, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      cycle("stl2", 32'h000081B3, 32'h2C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("stall.imm_c", dif.imm_exec, 32'd5);
      chk("stall.pc_c", dif.pc_exec, 32'h20);
      cycle("flush", 32'h00500093, 32'h30, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      chk("flush.pc_c", dif.pc_exec, 32'h0);
      chk("flush.rw_c", 32'(dif.reg_write_exec), 32'd0);
      // x2 was written during the stall; read it back now.
      cycle("x2rd", 32'h00010133, 32'h34, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("x2rd.rd1_c", dif.rd1_exec, 32'hCAFE);

      cycle("ill", 32'hFFFFFFFF, 32'h38, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("ill.ctl_c", 32'({dif.illegal_exec, dif.reg_write_exec, dif.mem_write_exec}), 32'h4);

      for (int n = 0; n < 300; n++) begin
         r = $urandom();
         cycle("rnd", {r[31:7], ops[$urandom_range(0, 9)]}, $urandom() & 32'hFFFF_FFFC,
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
      end

      // Write x1, reset between edges, confirm bubble and cleared register file.
      cycle("wx1", 32'h00000013, 32'h40, 1'b0, 1'b0, 1'b1, 5'd1, 32'hDEADBEEF);
      cycle("rx1", 32'h000081B3, 32'h44, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      reset_pulse("rstp");
      cycle("rst_stall", 32'h000081B3, 32'h48, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("rst_stall.rw_c", 32'(dif.reg_write_exec), 32'd0);
      cycle("rst_cap", 32'h000081B3, 32'h4C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("rst_cap.rd1_c", dif.rd1_exec, 32'h0);
      chk("rst_cap.pc_c", dif.pc_exec, 32'h4C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
